falling_block_lane: RTL
=======================

# falling_block_lane

Multi-slot falling-block generator for one piano lane, parametrised in slot depth, height width and screen geometry. It watches the shared beat counter and spawns blocks on the beats flagged in a level-supplied pattern mask. Each live block advances at a level-dependent speed, and the block resolves key presses into hit, miss and bad-press events. It sits between the beat/level controller and the VGA renderer and scorer; the top level instantiates one per lane.

## Interface
- DEPTH, 4, number of concurrent block slots (2..8)
- H_W, 10, height width in bits
- BEAT_W, 7, beat counter width
- SPAWN_H, 120, height loaded at spawn
- BOTTOM_H, 720, height at or beyond which a block is missed
- HIT_LO / HIT_HI, 600 / 680, inclusive hit window
---
- clk  in  1  game tick clock
- rst_n  in  1  reset, asynchronous, active-low
- restart  in  1  synchronous clear, same effect as reset
- pause  in  1  freeze: stop/end-game
- level  in  2  speed select
- beat_cnt  in  BEAT_W  global beat counter
- spawn_pattern  in  2**BEAT_W  bit b=1 spawns on beat b
- key_press  in  1  one-cycle key pulse for this lane
- blk_h  out  DEPTH*H_W  slot heights, slot i at [i*H_W +: H_W]
- blk_valid  out  DEPTH  slot live flags
- hit_pulse, miss_pulse, bad_press, overflow  out  1 each  one-cycle event pulses
- miss_num  out  $clog2(DEPTH+1)  blocks missed this cycle
- score  out  16  hit counter (see Configuration)

## Operation
- Beat edge: register prev_beat. beat_new = (beat_cnt != prev_beat), so the wrap from 2**BEAT_W-1 to 0 counts as an edge. prev_beat updates every cycle, including during pause.
- Spawn: requires beat_new, spawn_pattern[beat_cnt] and !pause. Spawn loads the lowest-index slot free at cycle start with SPAWN_H and sets its valid flag. If no slot is free, overflow pulses and the spawn is dropped.
- Move: each valid slot not spawned or cleared this cycle advances by step = level+1 px. If h+step >= BOTTOM_H the slot is freed instead and counts toward miss_num. miss_pulse = (miss_num != 0).
- Hit: on key_press && !pause, select the valid slot with the largest h inside [HIT_LO, HIT_HI]; ties go to the lowest index.
  - If a slot is selected, it is freed and hit_pulse fires.
  - If no slot qualifies, bad_press fires.
- Hit is evaluated on pre-move heights. A hit slot neither moves nor misses that cycle.
- Slots freed this cycle cannot be reused by a spawn until the next cycle.
- pause=1 holds all heights and valid flags and suppresses spawn, hit and bad_press. Beats that pass during pause never spawn afterwards.
- Arithmetic is done in H_W+1 bits so the move never wraps.

## Timing
- Reset/restart values:
  - blk_valid = 0 and all blk_h = 0.
  - prev_beat = 0.
  - All pulses = 0.
  - score = 0.
- All outputs are registered. An event sampled at edge t is visible after edge t; pulses last exactly one cycle.
- Spawn latency: beat_cnt changes before edge t, so the slot shows SPAWN_H after edge t and first moves at edge t+1.
- Restart wins over every event in the same cycle.
- Reset asserted mid-game clears immediately (asynchronous).

## Configuration
- LANE_SCORE_EN defined: score is a 16-bit counter, +1 per hit_pulse, saturating at 0xFFFF, cleared by reset/restart.
- LANE_SCORE_EN undefined: the score port remains but is tied to 0, and no counter logic is built.

## Structure
- Shared package piano_pkg holds:
  - H_W, BEAT_W and the geometry constants.
  - A level_step(level) function.
  - An event typedef struct {hit, miss, bad, ovf}.
- Sub-module lane_slot_pick: parametrised lowest-index priority encoder returning {found, idx}. It is instantiated twice: once for the free-slot search and once for the hit-candidate search, with the largest-h comparison done in the parent.

## Test plan
- Reset, level=0, pattern bit 11 set, beat 10→11: slot0=120 after that edge, 121 next; no further spawn while beat stays 11.
- level=3, slot0 at 716: next edge frees slot0 with miss_pulse=1, miss_num=1.
- Blocks at 610 and 650, key_press: the 650 block is cleared, hit_pulse=1, and 610 moves on. key_press with no block in the window gives bad_press=1.
- DEPTH=4 all live plus a spawn beat: overflow=1 and valid stays 4'b1111. pause=1 over beats 35..41: no spawn after unpause, heights frozen.
- Beat wrap 127→0 with pattern bit 0: spawns. Restart concurrent with a hit: everything cleared and no hit_pulse. With LANE_SCORE_EN, three hits give score=3.

Source files
------------

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared lane geometry, level speed and event types
package piano_pkg;

  localparam int H_W      = 10;
  localparam int BEAT_W   = 7;
  localparam int SPAWN_H  = 120;
  localparam int BOTTOM_H = 720;
  localparam int HIT_LO   = 600;
  localparam int HIT_HI   = 680;

  typedef struct packed {
    logic hit;
    logic miss;
    logic bad;
    logic ovf;
  } lane_evt_t;

  // Pixels per tick: level 0..3 moves 1..4 px.
  function automatic logic [2:0] level_step(input logic [1:0] lvl);
    return 3'(lvl) + 3'd1;
  endfunction

endpackage

// File: rtl/lane_slot_pick.sv
// rtl/lane_slot_pick.sv - lowest-index priority encoder returning {found, idx}
module lane_slot_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/falling_block_lane.sv
// rtl/falling_block_lane.sv - multi-slot falling-block generator for one piano lane
// Define LANE_SCORE_EN to build the saturating 16-bit hit counter on score.
module falling_block_lane
  import piano_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int H_W      = piano_pkg::H_W,
  parameter int BEAT_W   = piano_pkg::BEAT_W,
  parameter int SPAWN_H  = piano_pkg::SPAWN_H,
  parameter int BOTTOM_H = piano_pkg::BOTTOM_H,
  parameter int HIT_LO   = piano_pkg::HIT_LO,
  parameter int HIT_HI   = piano_pkg::HIT_HI
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         restart,
  input  logic                         pause,
  input  logic [1:0]                   level,
  input  logic [BEAT_W-1:0]            beat_cnt,
  input  logic [2**BEAT_W-1:0]         spawn_pattern,
  input  logic                         key_press,
  output logic [DEPTH*H_W-1:0]         blk_h,
  output logic [DEPTH-1:0]             blk_valid,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         bad_press,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   miss_num,
  output logic [15:0]                  score
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int MW    = $clog2(DEPTH + 1);
  localparam logic [H_W:0] SPAWN_X  = (H_W+1)'(SPAWN_H);
  localparam logic [H_W:0] BOTTOM_X = (H_W+1)'(BOTTOM_H);
  localparam logic [H_W:0] HIT_LO_X = (H_W+1)'(HIT_LO);
  localparam logic [H_W:0] HIT_HI_X = (H_W+1)'(HIT_HI);

  logic [H_W-1:0]   h_q [DEPTH];
  logic [H_W-1:0]   h_n [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_n;
  logic [BEAT_W-1:0] prev_beat;
  lane_evt_t        evt_q, evt_n;
  logic [MW-1:0]    miss_q, miss_n;

  logic [DEPTH-1:0] in_win, cand;
  logic [H_W-1:0]   best_h;
  logic             free_found, hit_found;
  logic [IDX_W-1:0] free_idx, hit_idx;
  logic             spawn_req, do_spawn, do_hit;
  logic [H_W:0]     step_x, sum_x;

  // Window membership and the tallest in-window height, on pre-move heights.
  always_comb begin
    in_win = '0;
    best_h = '0;
    for (int i = 0; i < DEPTH; i++) begin
      in_win[i] = valid_q[i] && ({1'b0, h_q[i]} >= HIT_LO_X) && ({1'b0, h_q[i]} <= HIT_HI_X);
      if (in_win[i] && h_q[i] > best_h) best_h = h_q[i];
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) cand[i] = in_win[i] && (h_q[i] == best_h);
  end

  lane_slot_pick #(.N(DEPTH)) u_free_pick (
    .req   (~valid_q),
    .found (free_found),
    .idx   (free_idx)
  );

  lane_slot_pick #(.N(DEPTH)) u_hit_pick (
    .req   (cand),
    .found (hit_found),
    .idx   (hit_idx)
  );

  always_comb begin
    step_x    = (H_W+1)'(level_step(level));
    spawn_req = (beat_cnt != prev_beat) && spawn_pattern[beat_cnt] && !pause;
    do_spawn  = spawn_req && free_found;
    do_hit    = key_press && !pause && hit_found;
    evt_n.hit  = do_hit;
    evt_n.bad  = key_press && !pause && !hit_found;
    evt_n.ovf  = spawn_req && !free_found;
    evt_n.miss = 1'b0;
    valid_n   = valid_q;
    miss_n    = '0;
    sum_x     = '0;
    for (int i = 0; i < DEPTH; i++) h_n[i] = h_q[i];
    if (!pause) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_hit && hit_idx == IDX_W'(i)) begin
          valid_n[i] = 1'b0;
          h_n[i]     = '0;
        end else if (do_spawn && free_idx == IDX_W'(i)) begin
          valid_n[i] = 1'b1;
          h_n[i]     = SPAWN_X[H_W-1:0];
        end else if (valid_q[i]) begin
          sum_x = {1'b0, h_q[i]} + step_x;
          if (sum_x >= BOTTOM_X) begin
            valid_n[i] = 1'b0;
            h_n[i]     = '0;
            miss_n     = miss_n + MW'(1);
          end else begin
            h_n[i] = sum_x[H_W-1:0];
          end
        end
      end
    end
    evt_n.miss = (miss_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) h_q[i] <= '0;
      valid_q   <= '0;
      prev_beat <= '0;
      evt_q     <= '0;
      miss_q    <= '0;
    end else if (restart) begin
      for (int i = 0; i < DEPTH; i++) h_q[i] <= '0;
      valid_q   <= '0;
      prev_beat <= '0;
      evt_q     <= '0;
      miss_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) h_q[i] <= h_n[i];
      valid_q   <= valid_n;
      prev_beat <= beat_cnt;
      evt_q     <= evt_n;
      miss_q    <= miss_n;
    end
  end

`ifdef LANE_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (restart) begin
      score_q <= '0;
    end else if (do_hit && score_q != 16'hFFFF) begin
      score_q <= score_q + 16'd1;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_h
    assign blk_h[g*H_W +: H_W] = h_q[g];
  end

  assign blk_valid  = valid_q;
  assign hit_pulse  = evt_q.hit;
  assign miss_pulse = evt_q.miss;
  assign bad_press  = evt_q.bad;
  assign overflow   = evt_q.ovf;
  assign miss_num   = miss_q;

endmodule
